// File: rtl/output_row_group.sv
// output_row_group: buffers staggered PE-array row results in per-row FIFOs,
// then drains them row by row, packing elements into scratchpad words that
// are written to consecutive addresses over a valid/ready handshake.
module output_row_group #(
    parameter int ROWS            = 4,
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
    parameter int FIFO_DEPTH      = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_reg_clear,
    input  logic                         i_en,
    input  logic [ADDR_WIDTH-1:0]        i_base_addr,
    input  logic [COUNT_WIDTH-1:0]       i_row_count,
    input  logic [ROWS*DATA_WIDTH-1:0]   i_data,
    input  logic [ROWS-1:0]              i_data_valid,
    output logic [SPAD_DATA_WIDTH-1:0]   o_spad_data,
    output logic [ADDR_WIDTH-1:0]        o_spad_addr,
    output logic                         o_spad_valid,
    input  logic                         i_spad_ready,
    output logic [ROWS-1:0]              o_full,
    output logic                         o_overflow,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W = (SPAD_N > 1) ? $clog2(SPAD_N) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(SPAD_N - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [ROWS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr   [ROWS];
    logic [PTR_W-1:0]      rd_ptr   [ROWS];
    logic [CNT_W-1:0]      fifo_cnt [ROWS];
    logic [ROWS-1:0]       full, empty, push, pop, drop;
    logic [DATA_WIDTH-1:0] pop_data;

    // Drain/pack state
    state_t                   state;
    logic [ROW_W-1:0]         row;
    logic [COUNT_WIDTH-1:0]   elem;
    logic [LANE_W-1:0]        lane;
    logic [COUNT_WIDTH-1:0]   row_count_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [SPAD_DATA_WIDTH-1:0] word_q;
    logic                     spad_valid_q, busy_q, done_q, overflow_q;

    // Per-row push/pop decisions; a pop frees a slot, so a full row still accepts a push
    always_comb begin
        full  = '0;
        empty = '0;
        pop   = '0;
        push  = '0;
        drop  = '0;
        for (int r = 0; r < ROWS; r++) begin
            full[r]  = (fifo_cnt[r] == CNT_FULL);
            empty[r] = (fifo_cnt[r] == '0);
            pop[r]   = (state == PACK) && (row == ROW_W'(r)) && !empty[r];
            push[r]  = i_data_valid[r] && (!full[r] || pop[r]);
            drop[r]  = i_data_valid[r] && full[r] && !pop[r];
        end
    end

    assign pop_data = mem[row][rd_ptr[row]];

    for (genvar g = 0; g < ROWS; g++) begin : g_fifo
        // Pointer and occupancy tracking for row g
        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                wr_ptr[g]   <= '0;
                rd_ptr[g]   <= '0;
                fifo_cnt[g] <= '0;
            end else if (i_reg_clear) begin
                wr_ptr[g]   <= '0;
                rd_ptr[g]   <= '0;
                fifo_cnt[g] <= '0;
            end else begin
                if (push[g]) wr_ptr[g] <= wr_ptr[g] + PTR_W'(1);
                if (pop[g])  rd_ptr[g] <= rd_ptr[g] + PTR_W'(1);
                case ({push[g], pop[g]})
                    2'b10:   fifo_cnt[g] <= fifo_cnt[g] + CNT_W'(1);
                    2'b01:   fifo_cnt[g] <= fifo_cnt[g] - CNT_W'(1);
                    default: fifo_cnt[g] <= fifo_cnt[g];
                endcase
            end
        end

        // Element storage for row g
        // NOTE: storage arrays carry no reset; clearing the pointers empties the FIFO logically.
        always_ff @(posedge i_clk) begin
            if (push[g]) mem[g][wr_ptr[g]] <= i_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Sticky record of any push dropped because its row was full
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)          overflow_q <= 1'b0;
        else if (i_reg_clear) overflow_q <= 1'b0;
        else if (|drop)       overflow_q <= 1'b1;
    end

    // Drain FSM: pack elements of the current row into a word, then write it out
    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state        <= IDLE;
            row          <= '0;
            elem         <= '0;
            lane         <= '0;
            row_count_q  <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            spad_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (i_reg_clear) begin
            state        <= IDLE;
            row          <= '0;
            elem         <= '0;
            lane         <= '0;
            row_count_q  <= '0;
            addr_q       <= '0;
            word_q       <= '0;
            spad_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_en) begin
                        addr_q      <= i_base_addr;
                        row_count_q <= i_row_count;
                        row         <= '0;
                        elem        <= '0;
                        lane        <= '0;
                        word_q      <= '0;
                        busy_q      <= 1'b1;
                        state       <= PACK;
                    end
                end
                PACK: begin
                    if (!empty[row]) begin
                        word_q[lane*DATA_WIDTH +: DATA_WIDTH] <= pop_data;
                        lane <= lane + LANE_W'(1);
                        elem <= elem + COUNT_WIDTH'(1);
                        if (lane == LANE_LAST || (elem + COUNT_WIDTH'(1)) == row_count_q) begin
                            spad_valid_q <= 1'b1;
                            state        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (i_spad_ready) begin
                        spad_valid_q <= 1'b0;
                        addr_q       <= addr_q + ADDR_WIDTH'(1);
                        word_q       <= '0;
                        lane         <= '0;
                        state        <= PACK;
                        if (elem == row_count_q) begin
                            elem <= '0;
                            if (row == ROW_LAST) begin
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_spad_data  = word_q;
    assign o_spad_addr  = addr_q;
    assign o_spad_valid = spad_valid_q;
    assign o_full       = full;
    assign o_overflow   = overflow_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
